// File: rtl/psum_seq_ctrl.sv
// Purpose : frame sequencer for the conv psum datapath; walks col/row, flags complete KERNELxKERNEL windows.
// Latency : window flag appears PIPE_LAT cycles after its beat; o_done PIPE_LAT+1 cycles after the last beat.
// Backpr. : o_ready is high only in RUN; i_valid low stalls col/row and the datapath shift enable.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   i_start             frame start request (only honoured in IDLE)
//   o_busy / o_done     high in RUN or FLUSH / one-cycle end-of-frame pulse
//   i_valid / o_ready   pixel handshake; o_shift_en = i_valid & o_ready
//   o_col / o_row       position of the beat that would be accepted this cycle
//   o_win_valid         psum at datapath output is a complete window
//   o_win_last          qualifies the final o_win_valid of the frame
//   o_stall_cnt         (only with PSUM_SEQ_PERF_EN) RUN cycles with i_valid low, saturating
//
// Optional feature macro: PSUM_SEQ_PERF_EN
module psum_seq_ctrl #(
    parameter int IMG_W    = 28,
    parameter int IMG_H    = 28,
    parameter int KERNEL   = 3,
    parameter int PIPE_LAT = 2,
    localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1,
    localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_start,
    output logic          o_busy,
    output logic          o_done,
    input  logic          i_valid,
    output logic          o_ready,
    output logic          o_shift_en,
    output logic [CW-1:0] o_col,
    output logic [RW-1:0] o_row,
    output logic          o_win_valid,
`ifdef PSUM_SEQ_PERF_EN
    output logic          o_win_last,
    output logic [31:0]   o_stall_cnt
`else
    output logic          o_win_last
`endif
);

    localparam int FW = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;

    localparam logic [CW-1:0] COL_MAX = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_MAX = RW'(IMG_H - 1);
    localparam logic [CW-1:0] COL_K1  = CW'(KERNEL - 1);
    localparam logic [RW-1:0] ROW_K1  = RW'(KERNEL - 1);
    localparam logic [FW-1:0] FL_MAX  = FW'(PIPE_LAT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_FLUSH,
        S_DONE
    } state_t;

    state_t              state;
    logic [CW-1:0]       col;
    logic [RW-1:0]       row;
    logic [FW-1:0]       flush_cnt;
    logic                busy_q;
    logic                done_q;
    logic                ready_q;
    logic [PIPE_LAT-1:0] win_sr;
    logic [PIPE_LAT-1:0] last_sr;

    logic col_end;
    logic row_end;
    logic win_term;
    logic last_term;

    assign o_shift_en = i_valid & ready_q;

    always_comb begin
        col_end   = (col == COL_MAX);
        row_end   = (row == ROW_MAX);
        win_term  = o_shift_en && (col >= COL_K1) && (row >= ROW_K1);
        // The final beat always lies in a complete window (IMG_W, IMG_H >= KERNEL).
        last_term = o_shift_en && col_end && row_end;
    end

    // Control FSM. Registered outputs are updated together with the state so
    // they line up with it exactly. On the final beat col/row are not advanced,
    // so they keep showing the last position through FLUSH and DONE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            col       <= '0;
            row       <= '0;
            flush_cnt <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            ready_q   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (i_start) begin
                        state   <= S_RUN;
                        col     <= '0;
                        row     <= '0;
                        busy_q  <= 1'b1;
                        ready_q <= 1'b1;
                    end
                end
                S_RUN: begin
                    if (o_shift_en) begin
                        if (col_end && row_end) begin
                            state     <= S_FLUSH;
                            ready_q   <= 1'b0;
                            flush_cnt <= '0;
                        end else if (col_end) begin
                            col <= '0;
                            row <= row + 1'b1;
                        end else begin
                            col <= col + 1'b1;
                        end
                    end
                end
                S_FLUSH: begin
                    if (flush_cnt == FL_MAX) begin
                        state  <= S_DONE;
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                    end else begin
                        flush_cnt <= flush_cnt + 1'b1;
                    end
                end
                S_DONE: begin
                    state  <= S_IDLE;
                    done_q <= 1'b0;
                end
                default: begin
                    state   <= S_IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    ready_q <= 1'b0;
                end
            endcase
        end
    end

    // Window flags track the datapath latency. They shift every cycle (not
    // only on o_shift_en) so the tail of the frame drains during FLUSH.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            win_sr  <= '0;
            last_sr <= '0;
        end else begin
            win_sr[0]  <= win_term;
            last_sr[0] <= last_term;
            for (int i = 1; i < PIPE_LAT; i++) begin
                win_sr[i]  <= win_sr[i-1];
                last_sr[i] <= last_sr[i-1];
            end
        end
    end

    assign o_busy      = busy_q;
    assign o_done      = done_q;
    assign o_ready     = ready_q;
    assign o_col       = col;
    assign o_row       = row;
    assign o_win_valid = win_sr[PIPE_LAT-1];
    assign o_win_last  = last_sr[PIPE_LAT-1];

`ifdef PSUM_SEQ_PERF_EN
    logic [31:0] stall_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if (state == S_IDLE && i_start) begin
            stall_cnt <= '0;
        end else if (state == S_RUN && !i_valid && stall_cnt != '1) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end

    assign o_stall_cnt = stall_cnt;
`endif

endmodule

// File: tb/tb_psum_seq_ctrl.sv
// Purpose : bench for psum_seq_ctrl with a 5x5/K3/LAT2 instance and a 4x4/K1/LAT1 instance.
// Latency : expected window flags are queued at each accepted beat with their due cycle.
// Backpr. : i_valid patterns include continuous and every-other-cycle streams.
module tb_psum_seq_ctrl;

    localparam int A_W = 5, A_H = 5, A_K = 3, A_L = 2, A_N = A_W * A_H;
    localparam int B_W = 4, B_H = 4, B_K = 1, B_L = 1, B_N = B_W * B_H;

    typedef struct {
        int due;
        bit last;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Instance A
    logic       a_start = 1'b0, a_valid = 1'b0;
    logic       a_busy, a_done, a_ready, a_shift_en, a_win_valid, a_win_last;
    logic [2:0] a_col, a_row;
    // Instance B
    logic       b_start = 1'b0, b_valid = 1'b0;
    logic       b_busy, b_done, b_ready, b_shift_en, b_win_valid, b_win_last;
    logic [1:0] b_col, b_row;
`ifdef PSUM_SEQ_PERF_EN
    logic [31:0] a_stall, b_stall;
`endif

    psum_seq_ctrl #(.IMG_W(A_W), .IMG_H(A_H), .KERNEL(A_K), .PIPE_LAT(A_L)) dut_a (
        .clk(clk), .rst(rst), .i_start(a_start), .o_busy(a_busy), .o_done(a_done),
        .i_valid(a_valid), .o_ready(a_ready), .o_shift_en(a_shift_en),
        .o_col(a_col), .o_row(a_row), .o_win_valid(a_win_valid),
`ifdef PSUM_SEQ_PERF_EN
        .o_win_last(a_win_last), .o_stall_cnt(a_stall)
`else
        .o_win_last(a_win_last)
`endif
    );

    psum_seq_ctrl #(.IMG_W(B_W), .IMG_H(B_H), .KERNEL(B_K), .PIPE_LAT(B_L)) dut_b (
        .clk(clk), .rst(rst), .i_start(b_start), .o_busy(b_busy), .o_done(b_done),
        .i_valid(b_valid), .o_ready(b_ready), .o_shift_en(b_shift_en),
        .o_col(b_col), .o_row(b_row), .o_win_valid(b_win_valid),
`ifdef PSUM_SEQ_PERF_EN
        .o_win_last(b_win_last), .o_stall_cnt(b_stall)
`else
        .o_win_last(b_win_last)
`endif
    );

    // Scoreboard state per instance
    exp_t sb_a[$];
    exp_t sb_b[$];
    int k_a = 0, wins_a = 0, done_a = 0, lastb_a = 0;
    int k_b = 0, wins_b = 0, done_b = 0, lastb_b = 0;

    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            if (a_ready) begin
                check_eq("a_col", int'(a_col), k_a % A_W);
                check_eq("a_row", int'(a_row), k_a / A_W);
            end
            if (a_shift_en) begin
                if ((k_a % A_W) >= A_K - 1 && (k_a / A_W) >= A_K - 1)
                    sb_a.push_back('{due: cyc + A_L, last: (k_a == A_N - 1)});
                if (k_a == A_N - 1) lastb_a = cyc;
                k_a++;
            end
            if (a_win_valid) begin
                wins_a++;
                if (sb_a.size() == 0) check_eq("a_win_unexpected", int'(a_win_valid), 0);
                else begin
                    e = sb_a.pop_front();
                    check_eq("a_win_cyc", cyc, e.due);
                    check_eq("a_win_last", int'(a_win_last), int'(e.last));
                end
            end else if (a_win_last) begin
                check_eq("a_last_stray", int'(a_win_last), 0);
            end
            if (a_done) begin
                done_a++;
                check_eq("a_done_lat", cyc - lastb_a, A_L + 1);
                check_eq("a_done_busy", int'(a_busy), 0);
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            if (b_ready) begin
                check_eq("b_col", int'(b_col), k_b % B_W);
                check_eq("b_row", int'(b_row), k_b / B_W);
            end
            if (b_shift_en) begin
                if ((k_b % B_W) >= B_K - 1 && (k_b / B_W) >= B_K - 1)
                    sb_b.push_back('{due: cyc + B_L, last: (k_b == B_N - 1)});
                if (k_b == B_N - 1) lastb_b = cyc;
                k_b++;
            end
            if (b_win_valid) begin
                wins_b++;
                if (sb_b.size() == 0) check_eq("b_win_unexpected", int'(b_win_valid), 0);
                else begin
                    e = sb_b.pop_front();
                    check_eq("b_win_cyc", cyc, e.due);
                    check_eq("b_win_last", int'(b_win_last), int'(e.last));
                end
            end else if (b_win_last) begin
                check_eq("b_last_stray", int'(b_win_last), 0);
            end
            if (b_done) begin
                done_b++;
                check_eq("b_done_lat", cyc - lastb_b, B_L + 1);
            end
        end
    end

    // All frame tasks are entered and left at posedge+1 of an IDLE cycle.
    task automatic frame_a(input bit gaps, input bit poke);
        int g;
        k_a = 0; wins_a = 0; done_a = 0; sb_a.delete();
        check_eq("a_idle_rdy", int'(a_ready), 0);
        a_start = 1'b1;
        @(posedge clk); #1 a_start = 1'b0;
        check_eq("a_start_rdy", int'(a_ready), 1);
        check_eq("a_start_busy", int'(a_busy), 1);
        g = 0;
        while (k_a < A_N && g < 200) begin
            a_valid = gaps ? (g % 2 == 0) : 1'b1;
            a_start = poke && (g == 7);
            @(posedge clk); #1;
            g++;
        end
        a_valid = 1'b0;
        a_start = poke;
        check_eq("a_beats", k_a, A_N);
        check_eq("a_flush_rdy", int'(a_ready), 0);
        check_eq("a_flush_busy", int'(a_busy), 1);
        g = 0;
        while (done_a == 0 && g < 20) begin
            @(posedge clk); #1;
            a_start = 1'b0;
            g++;
        end
        check_eq("a_done_seen", done_a, 1);
        check_eq("a_end_busy", int'(a_busy), 0);
        check_eq("a_end_rdy", int'(a_ready), 0);
        check_eq("a_win_count", wins_a, (A_W - A_K + 1) * (A_H - A_K + 1));
        check_eq("a_sb_empty", sb_a.size(), 0);
`ifdef PSUM_SEQ_PERF_EN
        check_eq("a_stall_cnt", int'(a_stall), gaps ? A_N - 1 : 0);
`endif
    endtask

    task automatic frame_b();
        int g;
        k_b = 0; wins_b = 0; done_b = 0; sb_b.delete();
        check_eq("b_idle_rdy", int'(b_ready), 0);
        b_start = 1'b1;
        @(posedge clk); #1 b_start = 1'b0;
        check_eq("b_start_rdy", int'(b_ready), 1);
        check_eq("b_start_col", int'(b_col), 0);
        check_eq("b_start_row", int'(b_row), 0);
        g = 0;
        while (k_b < B_N && g < 100) begin
            b_valid = 1'b1;
            @(posedge clk); #1;
            g++;
        end
        b_valid = 1'b0;
        check_eq("b_beats", k_b, B_N);
        g = 0;
        while (done_b == 0 && g < 20) begin
            @(posedge clk); #1;
            g++;
        end
        check_eq("b_done_seen", done_b, 1);
        check_eq("b_win_count", wins_b, B_N);
        check_eq("b_sb_empty", sb_b.size(), 0);
`ifdef PSUM_SEQ_PERF_EN
        check_eq("b_stall_cnt", int'(b_stall), 0);
`endif
    endtask

    initial begin
        int g;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_busy", int'(a_busy), 0);
        check_eq("rst_done", int'(a_done), 0);
        check_eq("rst_ready", int'(a_ready), 0);
        check_eq("rst_col", int'(a_col), 0);
        check_eq("rst_row", int'(a_row), 0);
        check_eq("rst_win", int'(a_win_valid | a_win_last), 0);
        rst = 1'b0;
        @(posedge clk); #1;

        frame_a(1'b0, 1'b0);     // continuous stream
        frame_a(1'b1, 1'b0);     // valid every other cycle

        // Reset in the middle of a frame, at beat 10
        k_a = 0; wins_a = 0; done_a = 0; sb_a.delete();
        a_start = 1'b1;
        @(posedge clk); #1 a_start = 1'b0;
        g = 0;
        while (k_a < 10 && g < 50) begin
            a_valid = 1'b1;
            @(posedge clk); #1;
            g++;
        end
        check_eq("mid_beats", k_a, 10);
        rst = 1'b1;
        #1;
        check_eq("mid_busy", int'(a_busy), 0);
        check_eq("mid_ready", int'(a_ready), 0);
        check_eq("mid_shift", int'(a_shift_en), 0);
        check_eq("mid_col", int'(a_col), 0);
        check_eq("mid_row", int'(a_row), 0);
        check_eq("mid_win", int'(a_win_valid | a_win_last), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        a_valid = 1'b0;
        sb_a.delete();
        repeat (6) @(posedge clk);
        #1;
        check_eq("mid_no_done", done_a, 0);
        check_eq("mid_no_win", wins_a, 0);
        frame_a(1'b0, 1'b0);     // clean frame after reset

        frame_a(1'b0, 1'b1);     // i_start poked in RUN and FLUSH

        frame_b();               // KERNEL=1
        frame_b();               // started in the cycle after DONE

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
